// File: rtl/core_bus_arb_pkg.sv
// Shared types for the two-master core bus arbiter: master ids and the
// request payload carried from either master to the slave port.
package core_bus_pkg;

    typedef logic [0:0] mst_id_t;

    localparam mst_id_t MST_IBUS = 1'b0;
    localparam mst_id_t MST_DBUS = 1'b1;
    localparam int      NUM_MST  = 2;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;

    typedef struct packed {
        logic [BUS_AW-1:0]   addr;
        logic [BUS_DW-1:0]   wdata;
        logic [BUS_DW/8-1:0] sel;
        logic                we;
    } bus_req_t;

endpackage

// File: rtl/core_bus_arb_id_fifo.sv
// Small synchronous FIFO holding the owner id of each accepted transaction
// so that in-order responses can be steered back to the issuing master.
module arb_id_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push, do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop)  rd_ptr <= nxt(rd_ptr);
            if (do_push && !do_pop)      cnt <= cnt + 1'b1;
            else if (do_pop && !do_push) cnt <= cnt - 1'b1;
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/core_bus_arb.sv
// Two-master (ibus/dbus) to one-slave arbiter with round-robin grant,
// handshake lock and an owner FIFO for in-order response routing.
module core_bus_arb
    import core_bus_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*AW-1:0]       m_addr_i,
    input  logic [2*DW-1:0]       m_wdata_i,
    input  logic [2*(DW/8)-1:0]   m_sel_i,
    input  logic [1:0]            m_we_i,
    input  logic [1:0]            m_req_valid_i,
    output logic [1:0]            m_req_ready_o,
    output logic [1:0]            m_rsp_valid_o,
    input  logic [1:0]            m_rsp_ready_i,
    output logic [2*DW-1:0]       m_rdata_o,
    output logic [AW-1:0]         s_addr_o,
    output logic [DW-1:0]         s_wdata_o,
    output logic [DW/8-1:0]       s_sel_o,
    output logic                  s_we_o,
    output logic                  s_req_valid_o,
    input  logic                  s_req_ready_i,
    input  logic                  s_rsp_valid_i,
    output logic                  s_rsp_ready_o,
    input  logic [DW-1:0]         s_rdata_i
);
    localparam int SW = DW / 8;

    bus_req_t mreq [NUM_MST];
    bus_req_t sreq;

    for (genvar g = 0; g < NUM_MST; g++) begin : g_slice
        assign mreq[g].addr  = m_addr_i[g*AW +: AW];
        assign mreq[g].wdata = m_wdata_i[g*DW +: DW];
        assign mreq[g].sel   = m_sel_i[g*SW +: SW];
        assign mreq[g].we    = m_we_i[g];
    end

    logic    last_grant_q, lock_q;
    mst_id_t lock_id_q;
    mst_id_t grant, head;
    logic    gnt_vld, full, empty, push, pop;

    always_comb begin
        gnt_vld = 1'b0;
        grant   = MST_IBUS;
        if (lock_q) begin
            gnt_vld = 1'b1;
            grant   = lock_id_q;
        end else begin
            unique case (m_req_valid_i)
                2'b01:   begin gnt_vld = 1'b1; grant = MST_IBUS; end
                2'b10:   begin gnt_vld = 1'b1; grant = MST_DBUS; end
                2'b11:   begin gnt_vld = 1'b1; grant = mst_id_t'(!last_grant_q); end
                default: ;
            endcase
        end
    end

    // Reset gating keeps all handshakes quiet while rst is held.
    always_comb begin
        s_req_valid_o = !rst && gnt_vld && m_req_valid_i[grant] && !full;
        m_req_ready_o = '0;
        if (!rst && gnt_vld && !full && s_req_ready_i)
            m_req_ready_o[grant] = 1'b1;
    end

    assign sreq      = mreq[gnt_vld ? grant : MST_IBUS];
    assign s_addr_o  = sreq.addr;
    assign s_wdata_o = sreq.wdata;
    assign s_sel_o   = sreq.sel;
    assign s_we_o    = sreq.we;

    assign push = s_req_valid_o && s_req_ready_i;

    always_comb begin
        m_rsp_valid_o = '0;
        s_rsp_ready_o = 1'b0;
        if (!empty) begin
            m_rsp_valid_o[head] = s_rsp_valid_i;
            s_rsp_ready_o       = m_rsp_ready_i[head];
        end
    end

    assign pop       = s_rsp_valid_i && s_rsp_ready_o;
    assign m_rdata_o = {2{s_rdata_i}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b0;
            lock_q       <= 1'b0;
            lock_id_q    <= MST_IBUS;
        end else begin
            if (push) begin
                last_grant_q <= grant;
                lock_q       <= 1'b0;
            end else if (s_req_valid_o) begin
                lock_q    <= 1'b1;
                lock_id_q <= grant;
            end
        end
    end

    arb_id_fifo #(
        .DEPTH (OUTSTANDING),
        .W     (1)
    ) u_owner_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (grant),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_core_bus_arb.sv
// Directed bench for core_bus_arb: grant order, lock, FIFO full/no-bypass,
// response backpressure and reset mid-transaction.
module tb_core_bus_arb;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [2*AW-1:0] m_addr_i;
    logic [2*DW-1:0] m_wdata_i;
    logic [7:0]      m_sel_i;
    logic [1:0]      m_we_i, m_req_valid_i, m_req_ready_o, m_rsp_valid_o, m_rsp_ready_i;
    logic [2*DW-1:0] m_rdata_o;
    logic [AW-1:0]   s_addr_o;
    logic [DW-1:0]   s_wdata_o, s_rdata_i;
    logic [3:0]      s_sel_o;
    logic            s_we_o, s_req_valid_o, s_req_ready_i, s_rsp_valid_i, s_rsp_ready_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    core_bus_arb #(.AW(AW), .DW(DW), .OUTSTANDING(2)) dut (
        .clk(clk), .rst(rst),
        .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
        .m_req_valid_i(m_req_valid_i), .m_req_ready_o(m_req_ready_o),
        .m_rsp_valid_o(m_rsp_valid_o), .m_rsp_ready_i(m_rsp_ready_i), .m_rdata_o(m_rdata_o),
        .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_req_valid_o(s_req_valid_o), .s_req_ready_i(s_req_ready_i),
        .s_rsp_valid_i(s_rsp_valid_i), .s_rsp_ready_o(s_rsp_ready_o), .s_rdata_i(s_rdata_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks run mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        rst = 1'b1;
        m_addr_i = '0; m_wdata_i = '0; m_sel_i = '0; m_we_i = '0;
        m_req_valid_i = 2'b11; m_rsp_ready_i = 2'b11;
        s_req_ready_i = 1'b1; s_rsp_valid_i = 1'b0; s_rdata_i = '0;
        settle();
        chk("rst_req_ready", m_req_ready_o, 2'b00);
        chk("rst_s_valid", s_req_valid_o, 1'b0);
        chk("rst_rsp_ready", s_rsp_ready_o, 1'b0);
        tick(); tick();
        rst = 1'b0;
        m_req_valid_i = 2'b00;

        // single ibus read
        m_addr_i = {32'h0, 32'h0000_0100};
        m_req_valid_i = 2'b01;
        settle();
        chk("t1_req_ready", m_req_ready_o, 2'b01);
        chk("t1_s_addr", s_addr_o, 32'h0000_0100);
        tick();
        m_req_valid_i = 2'b00;
        s_rsp_valid_i = 1'b1; s_rdata_i = 32'hDEAD_BEEF;
        settle();
        chk("t1_rsp_valid", m_rsp_valid_o, 2'b01);
        chk("t1_rdata0", m_rdata_o[31:0], 32'hDEAD_BEEF);
        tick();
        s_rsp_valid_i = 1'b0;

        // contention: last grant was ibus, so dbus first
        m_addr_i = {32'h2000_0000, 32'h0000_0100};
        m_req_valid_i = 2'b11;
        settle();
        chk("t2_addr_dbus", s_addr_o, 32'h2000_0000);
        chk("t2_ready_dbus", m_req_ready_o, 2'b10);
        tick();
        m_req_valid_i = 2'b01;
        settle();
        chk("t2_addr_ibus", s_addr_o, 32'h0000_0100);
        chk("t2_ready_ibus", m_req_ready_o, 2'b01);
        tick();
        m_req_valid_i = 2'b00;
        s_rsp_valid_i = 1'b1; s_rdata_i = 32'h1111_1111;
        settle();
        chk("t2_rsp_first", m_rsp_valid_o, 2'b10);
        tick();
        s_rdata_i = 32'h2222_2222;
        settle();
        chk("t2_rsp_second", m_rsp_valid_o, 2'b01);
        tick();
        s_rsp_valid_i = 1'b0;

        // dbus write so the round-robin pointer favours ibus next
        m_addr_i = {32'h2000_0004, 32'h0};
        m_we_i = 2'b10;
        m_req_valid_i = 2'b10;
        settle();
        chk("w_we", s_we_o, 1'b1);
        tick();
        m_req_valid_i = 2'b00; m_we_i = 2'b00;
        s_rsp_valid_i = 1'b1;
        settle();
        chk("w_rsp", m_rsp_valid_o, 2'b10);
        tick();
        s_rsp_valid_i = 1'b0;

        // lock: dbus stalled 3 cycles, ibus joins in cycle 1
        m_addr_i = {32'h3000_0000, 32'h0000_0400};
        m_req_valid_i = 2'b10;
        s_req_ready_i = 1'b0;
        settle();
        chk("t3_c0_valid", s_req_valid_o, 1'b1);
        chk("t3_c0_addr", s_addr_o, 32'h3000_0000);
        tick();
        m_req_valid_i = 2'b11;
        for (int c = 1; c < 3; c++) begin
            settle();
            chk("t3_locked_addr", s_addr_o, 32'h3000_0000);
            chk("t3_locked_ready", m_req_ready_o, 2'b00);
            tick();
        end
        s_req_ready_i = 1'b1;
        settle();
        chk("t3_accept_dbus", m_req_ready_o, 2'b10);
        tick();
        m_req_valid_i = 2'b01;
        settle();
        chk("t3_then_ibus", s_addr_o, 32'h0000_0400);
        tick();
        m_req_valid_i = 2'b00;
        s_rsp_valid_i = 1'b1;
        settle();
        chk("t3_rsp_dbus", m_rsp_valid_o, 2'b10);
        tick(); tick();
        s_rsp_valid_i = 1'b0;

        // three back-to-back ibus requests, FIFO depth 2
        m_addr_i = {32'h0, 32'h0000_0500};
        m_req_valid_i = 2'b01;
        settle();
        chk("t4_first", m_req_ready_o, 2'b01);
        tick();
        settle();
        chk("t4_second", m_req_ready_o, 2'b01);
        tick();
        settle();
        chk("t4_full_ready", m_req_ready_o, 2'b00);
        chk("t4_full_valid", s_req_valid_o, 1'b0);
        tick();
        // pop and blocked request in the same cycle: no bypass
        s_rsp_valid_i = 1'b1;
        settle();
        chk("t5_no_bypass", m_req_ready_o, 2'b00);
        chk("t5_pop_rsp", s_rsp_ready_o, 1'b1);
        tick();
        s_rsp_valid_i = 1'b0;
        settle();
        chk("t5_after_pop", m_req_ready_o, 2'b01);
        tick();
        m_req_valid_i = 2'b00;

        // response backpressure with full FIFO
        s_rsp_valid_i = 1'b1;
        m_rsp_ready_i = 2'b00;
        for (int c = 0; c < 2; c++) begin
            settle();
            chk("t6_rsp_ready_lo", s_rsp_ready_o, 1'b0);
            chk("t6_rsp_valid", m_rsp_valid_o, 2'b01);
            chk("t6_still_full", s_req_valid_o, 1'b0);
            m_req_valid_i = 2'b01;
            settle();
            chk("t6_block", m_req_ready_o, 2'b00);
            m_req_valid_i = 2'b00;
            tick();
        end
        m_rsp_ready_i = 2'b01;
        settle();
        chk("t6_rsp_ready_hi", s_rsp_ready_o, 1'b1);
        tick();
        s_rsp_valid_i = 1'b0;
        m_rsp_ready_i = 2'b11;
        m_req_valid_i = 2'b01;
        settle();
        chk("t6_refill", m_req_ready_o, 2'b01);
        tick();
        m_req_valid_i = 2'b00;

        // reset with 2 outstanding, stray response afterwards
        rst = 1'b1;
        s_rsp_valid_i = 1'b1;
        settle();
        chk("t7_rst_rsp_valid", m_rsp_valid_o, 2'b00);
        chk("t7_rst_rsp_ready", s_rsp_ready_o, 1'b0);
        tick();
        rst = 1'b0;
        settle();
        chk("t7_stray_ignored", m_rsp_valid_o, 2'b00);
        chk("t7_empty_ready", s_rsp_ready_o, 1'b0);
        tick();
        s_rsp_valid_i = 1'b0;
        m_addr_i = {32'h0000_0600, 32'h0};
        m_req_valid_i = 2'b10;
        settle();
        chk("t7_req_ok", m_req_ready_o, 2'b10);
        chk("t7_req_addr", s_addr_o, 32'h0000_0600);
        tick();
        m_req_valid_i = 2'b00;
        s_rsp_valid_i = 1'b1;
        settle();
        chk("t7_rsp_route", m_rsp_valid_o, 2'b10);
        tick();
        s_rsp_valid_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/core_bus_arb.md
Name: core_bus_arb

Overview:
- Two-master to one-slave bus arbiter directly downstream of the core's ibus and dbus ports.
- Merges instruction fetch (master 0) and load/store (master 1) onto a single memory port.
- Uses the same req valid/ready plus rsp valid/ready handshake as the core.
- Tracks the owner of each outstanding transaction so responses return in order to the right master.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- OUTSTANDING, 2, maximum accepted-but-unanswered transactions (>=1). Sets the owner-FIFO depth.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- m_addr_i  in  2*AW  master addresses, packed; slice 0 = ibus, slice 1 = dbus.
- m_wdata_i  in  2*DW  master write data.
- m_sel_i  in  2*(DW/8)  master byte selects.
- m_we_i  in  2  master write enables.
- m_req_valid_i  in  2  master request valid.
- m_req_ready_o  out  2  request accepted, per master.
- m_rsp_valid_o  out  2  response valid, per master.
- m_rsp_ready_i  in  2  master ready for response.
- m_rdata_o  out  2*DW  read data; s_rdata_i broadcast to both slices.
- s_addr_o  out  AW  slave address.
- s_wdata_o  out  DW  slave write data.
- s_sel_o  out  DW/8  slave byte select.
- s_we_o  out  1  slave write enable.
- s_req_valid_o  out  1  slave request valid.
- s_req_ready_i  in  1  slave accepts request.
- s_rsp_valid_i  in  1  slave response valid.
- s_rsp_ready_o  out  1  arbiter ready for response.
- s_rdata_i  in  DW  slave read data.

Behaviour:
- Reset state:
  - owner FIFO empty.
  - last_grant_q = 0, so dbus wins the first contention.
  - lock_q = 0.
  - All valid/ready outputs are 0 while rst is high.
- Grant selection (combinational):
  - If lock_q, grant = lock_id_q.
  - Else if exactly one m_req_valid_i bit is set, grant that master.
  - Else if both are set, grant !last_grant_q (round-robin).
  - Else no grant.
- Request forwarding:
  - s_req_valid_o = granted master valid AND FIFO not full.
  - s_addr/wdata/sel/we_o = granted master's slice.
  - When no master is granted, the s_* payload outputs carry slice 0.
  - m_req_ready_o[grant] = s_req_ready_i AND FIFO not full; the other bit is 0.
- Lock:
  - Set when s_req_valid_o && !s_req_ready_i; lock_id_q = grant.
  - Cleared on acceptance.
  - The granted master may not be switched mid-handshake. The request must be held stable (same contract as the core).
- Accept event (s_req_valid_o && s_req_ready_i):
  - Push grant id into the owner FIFO.
  - last_grant_q <= grant.
  - Zero added latency: a request is presented on the slave in the same cycle the master asserts it.
- Full FIFO: requests are blocked (s_req_valid_o = 0) even if a pop occurs in the same cycle. No bypass.
- Response routing:
  - head = FIFO head id.
  - If FIFO is non-empty: m_rsp_valid_o[head] = s_rsp_valid_i, and s_rsp_ready_o = m_rsp_ready_i[head].
  - If FIFO is empty: s_rsp_ready_o = 0 and m_rsp_valid_o = 0. A stray s_rsp_valid_i is ignored.
- Pop event: s_rsp_valid_i && s_rsp_ready_o.
- Simultaneous push and pop with FIFO not full: both take effect; the count is unchanged.
- Single-beat transactions only. No error response and no write-without-response; every request gets exactly one response.
- Reset mid-transaction:
  - All state clears immediately (asynchronous reset).
  - Any in-flight slave response after reset is ignored because the FIFO is empty.

Decomposition:
- Package core_bus_pkg:
  - typedef mst_id_t (1 bit).
  - localparams MST_IBUS = 0, MST_DBUS = 1, NUM_MST = 2.
  - Request struct with fields addr, wdata, sel, we.
- Sub-module arb_id_fifo:
  - Parameterised depth/width synchronous FIFO with push, pop, full, empty, head.
  - Pointer and count registers, async active-high reset.

Test Plan:
- Single ibus read, addr 0x0000_0100, slave ready immediately, rsp 0xDEAD_BEEF next cycle -> m_req_ready_o = 01 in cycle 0; m_rsp_valid_o = 01 with m_rdata_o slice 0 = 0xDEAD_BEEF; m_rsp_valid_o[1] stays 0.
- Both masters valid out of reset, ibus 0x100, dbus 0x2000_0000 -> dbus granted first (s_addr_o = 0x2000_0000), then ibus; responses route 1 then 0.
- dbus presented while s_req_ready_i is low for 3 cycles, ibus asserts in cycle 1 -> grant stays dbus all 3 cycles; ibus waits; s_addr_o unchanged.
- OUTSTANDING = 2, three back-to-back ibus requests, no responses -> first two accepted; third sees m_req_ready_o[0] = 0 until the first response pops.
- FIFO full, response pop and new request in the same cycle -> request not accepted that cycle; accepted the following cycle.
- Response with m_rsp_ready_i[head] = 0 for 2 cycles -> s_rsp_ready_o = 0; FIFO head held; pop occurs only on the cycle ready rises.
- Assert rst with 2 outstanding, then drive s_rsp_valid_i = 1 -> all m_rsp_valid_o = 0; FIFO empty; next request accepted normally.
